// File: rtl/ysyx_25010008_arbiter_if.sv
// rtl/ysyx_25010008_arbiter_if.sv - IFU/LSU/memory bus bundle for the arbiter
interface ysyx_25010008_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_rdata;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_resp_ready
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, mem_resp_ready
  );
endinterface

// File: rtl/ysyx_25010008_arbiter.sv
// rtl/ysyx_25010008_arbiter.sv - round-robin IFU/LSU arbiter onto a single memory port
// One transaction in flight; request fields are latched on grant and replayed to memory.
module ysyx_25010008_arbiter (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25010008_arbiter_if.slave        bus
);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_IFU_REQ  = 3'd1;
  localparam logic [2:0] S_IFU_RESP = 3'd2;
  localparam logic [2:0] S_LSU_REQ  = 3'd3;
  localparam logic [2:0] S_LSU_RESP = 3'd4;

  logic [2:0]  state;
  logic        last_lsu;
  logic [31:0] hold_addr;
  logic        hold_wen;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wmask;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        req_fire;
  logic        resp_fire;

  // On contention the master that did not win last time is granted.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst && state == S_IDLE) begin
      grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || last_lsu);
      grant_lsu = bus.lsu_req_valid && !grant_ifu;
    end
  end

  always_comb begin
    bus.ifu_req_ready  = grant_ifu;
    bus.lsu_req_ready  = grant_lsu;
    bus.mem_req_valid  = !rst && (state == S_IFU_REQ || state == S_LSU_REQ);
    bus.mem_req_addr   = hold_addr;
    bus.mem_req_wen    = hold_wen;
    bus.mem_req_wdata  = hold_wdata;
    bus.mem_req_wmask  = hold_wmask;
    bus.mem_resp_ready = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_rdata = 32'd0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_rdata = 32'd0;
    if (!rst && state == S_IFU_RESP) begin
      bus.mem_resp_ready = bus.ifu_resp_ready;
      bus.ifu_resp_valid = bus.mem_resp_valid;
      bus.ifu_resp_rdata = bus.mem_resp_valid ? bus.mem_resp_rdata : 32'd0;
    end
    if (!rst && state == S_LSU_RESP) begin
      bus.mem_resp_ready = bus.lsu_resp_ready;
      bus.lsu_resp_valid = bus.mem_resp_valid;
      bus.lsu_resp_rdata = bus.mem_resp_valid ? bus.mem_resp_rdata : 32'd0;
    end
  end

  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign resp_fire = bus.mem_resp_valid && bus.mem_resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_lsu   <= 1'b1;
      hold_addr  <= 32'd0;
      hold_wen   <= 1'b0;
      hold_wdata <= 32'd0;
      hold_wmask <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ifu) begin
            hold_addr  <= bus.ifu_req_addr;
            hold_wen   <= 1'b0;
            hold_wdata <= 32'd0;
            hold_wmask <= 4'd0;
            last_lsu   <= 1'b0;
            state      <= S_IFU_REQ;
          end else if (grant_lsu) begin
            hold_addr  <= bus.lsu_req_addr;
            hold_wen   <= bus.lsu_req_wen;
            hold_wdata <= bus.lsu_req_wdata;
            hold_wmask <= bus.lsu_req_wmask;
            last_lsu   <= 1'b1;
            state      <= S_LSU_REQ;
          end
        end
        S_IFU_REQ:  if (req_fire)  state <= S_IFU_RESP;
        S_IFU_RESP: if (resp_fire) state <= S_IDLE;
        S_LSU_REQ:  if (req_fire)  state <= S_LSU_RESP;
        S_LSU_RESP: if (resp_fire) state <= S_IDLE;
        default:                   state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25010008_arbiter.sv
// tb/tb_ysyx_25010008_arbiter.sv - randomized scoreboard bench for the IFU/LSU arbiter
module tb_ysyx_25010008_arbiter;
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25010008_arbiter_if bus ();

  ysyx_25010008_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  req_t        ifu_q[$];
  req_t        lsu_q[$];
  logic [31:0] resp_q[$];

  bit mon_en = 1'b0;
  bit m_busy = 1'b0;
  bit m_who = 1'b0;
  bit m_acc = 1'b0;
  bit m_last = 1'b1;
  bit m_wen = 1'b0;
  bit stall_prev = 1'b0;
  req_t prev_req;

  bit      mem_pending = 1'b0;
  bit      resp_real = 1'b0;
  int      mem_delay = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a transaction-level model of grant order and phase.
  always @(negedge clk) begin
    if (mon_en) begin
      req_t e;
      logic [31:0] r;
      bit resp_phase;
      resp_phase = m_busy && m_acc;
      chk1("ifu_req_ready", bus.ifu_req_ready, !m_busy && bus.ifu_req_valid && (!bus.lsu_req_valid || m_last));
      chk1("lsu_req_ready", bus.lsu_req_ready, !m_busy && bus.lsu_req_valid && (!bus.ifu_req_valid || !m_last));
      chk1("mem_req_valid", bus.mem_req_valid, m_busy && !m_acc);
      chk1("mem_resp_ready", bus.mem_resp_ready, resp_phase && (m_who ? bus.lsu_resp_ready : bus.ifu_resp_ready));
      chk1("ifu_resp_valid", bus.ifu_resp_valid, resp_phase && !m_who && bus.mem_resp_valid);
      chk1("lsu_resp_valid", bus.lsu_resp_valid, resp_phase && m_who && bus.mem_resp_valid);
      if (!bus.ifu_resp_valid) chk32("ifu_rdata_zero", bus.ifu_resp_rdata, 32'd0);
      if (!bus.lsu_resp_valid) chk32("lsu_rdata_zero", bus.lsu_resp_rdata, 32'd0);

      if (stall_prev) begin
        chk1("mem_req_held", bus.mem_req_valid, 1'b1);
        chk32("mem_req_addr_stable", bus.mem_req_addr, prev_req.addr);
        chk32("mem_req_wdata_stable", bus.mem_req_wdata, prev_req.wdata);
      end
      stall_prev = bus.mem_req_valid && !bus.mem_req_ready;
      prev_req = '{bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata, bus.mem_req_wmask};

      if (m_busy && !m_acc && bus.mem_req_valid && bus.mem_req_ready) begin
        if ((m_who ? lsu_q.size() : ifu_q.size()) == 0) begin
          chk1("mem_req_expected", 1'b0, 1'b1);
        end else begin
          e = m_who ? lsu_q.pop_front() : ifu_q.pop_front();
          chk32("mem_req_addr", bus.mem_req_addr, e.addr);
          chk1("mem_req_wen", bus.mem_req_wen, e.wen);
          chk32("mem_req_wdata", bus.mem_req_wdata, e.wdata);
          chk32("mem_req_wmask", {28'd0, bus.mem_req_wmask}, {28'd0, e.wmask});
          m_wen = e.wen;
        end
        m_acc = 1'b1;
      end else if (resp_phase && bus.mem_resp_valid && bus.mem_resp_ready) begin
        if (resp_q.size() == 0) begin
          chk1("resp_expected", 1'b0, 1'b1);
        end else begin
          r = resp_q.pop_front();
          if (!m_who) chk32("ifu_resp_rdata", bus.ifu_resp_rdata, r);
          else if (!m_wen) chk32("lsu_resp_rdata", bus.lsu_resp_rdata, r);
        end
        m_busy = 1'b0;
      end else if (!m_busy && bus.ifu_req_valid && bus.ifu_req_ready) begin
        m_busy = 1'b1; m_who = 1'b0; m_last = 1'b0; m_acc = 1'b0;
      end else if (!m_busy && bus.lsu_req_valid && bus.lsu_req_ready) begin
        m_busy = 1'b1; m_who = 1'b1; m_last = 1'b1; m_acc = 1'b0;
      end
    end
  end

  task automatic issue_ifu();
    bus.ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
    bus.ifu_req_valid = 1'b1;
    ifu_q.push_back('{bus.ifu_req_addr, 1'b0, 32'd0, 4'd0});
  endtask

  task automatic issue_lsu();
    bus.lsu_req_addr  = $urandom;
    bus.lsu_req_wen   = 1'($urandom_range(0, 1));
    bus.lsu_req_wdata = $urandom;
    bus.lsu_req_wmask = 4'($urandom_range(0, 15));
    bus.lsu_req_valid = 1'b1;
    lsu_q.push_back('{bus.lsu_req_addr, bus.lsu_req_wen, bus.lsu_req_wdata, bus.lsu_req_wmask});
  endtask

  // Driver: observes handshakes mid-cycle, then updates inputs just after the edge.
  task automatic step(input bit allow_new);
    bit f_ifu, f_lsu, f_mreq, f_mresp;
    @(negedge clk);
    f_ifu   = bus.ifu_req_valid && bus.ifu_req_ready;
    f_lsu   = bus.lsu_req_valid && bus.lsu_req_ready;
    f_mreq  = bus.mem_req_valid && bus.mem_req_ready;
    f_mresp = bus.mem_resp_valid && bus.mem_resp_ready;
    @(posedge clk);
    #1;
    if (f_ifu) bus.ifu_req_valid = 1'b0;
    if (f_lsu) bus.lsu_req_valid = 1'b0;
    if (allow_new && !bus.ifu_req_valid && $urandom_range(0, 2) == 0) issue_ifu();
    if (allow_new && !bus.lsu_req_valid && $urandom_range(0, 2) == 0) issue_lsu();
    bus.ifu_resp_ready = 1'($urandom_range(0, 1));
    bus.lsu_resp_ready = 1'($urandom_range(0, 1));
    bus.mem_req_ready  = ($urandom_range(0, 2) != 0);
    if (f_mresp) begin
      mem_pending = 1'b0;
      resp_real   = 1'b0;
    end
    if (f_mreq) begin
      mem_pending = 1'b1;
      mem_delay   = $urandom_range(0, 2);
    end
    if (!resp_real) bus.mem_resp_valid = 1'b0;
    if (mem_pending && !resp_real) begin
      if (mem_delay == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = $urandom;
        resp_real = 1'b1;
        resp_q.push_back(bus.mem_resp_rdata);
      end else begin
        mem_delay--;
      end
    end else if (!mem_pending) begin
      bus.mem_resp_valid = ($urandom_range(0, 4) == 0);
      bus.mem_resp_rdata = $urandom;
    end
  endtask

  function automatic bit drained();
    return !bus.ifu_req_valid && !bus.lsu_req_valid && ifu_q.size() == 0 && lsu_q.size() == 0 &&
           resp_q.size() == 0 && !mem_pending;
  endfunction

  initial begin
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1111_2222;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = 32'd0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = 32'd0;
    bus.lsu_req_wmask  = 4'd0;
    bus.ifu_req_addr   = 32'd0;
    bus.ifu_req_valid  = 1'b0;
    issue_ifu();
    issue_lsu();

    repeat (2) begin
      @(negedge clk);
      chk1("rst_ifu_req_ready", bus.ifu_req_ready, 1'b0);
      chk1("rst_lsu_req_ready", bus.lsu_req_ready, 1'b0);
      chk1("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
      chk1("rst_mem_resp_ready", bus.mem_resp_ready, 1'b0);
      chk1("rst_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
      chk1("rst_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 3000; i++) step(1'b1);
    for (int i = 0; i < 2000 && !drained(); i++) step(1'b0);
    chk1("drain_complete", drained(), 1'b1);

    // Abort a fetch stuck in the request phase, then offer a stale response.
    mon_en = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.ifu_req_addr   = 32'h8000_0000;
    bus.ifu_req_valid  = 1'b1;
    @(negedge clk);
    chk1("abort_grant", bus.ifu_req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    chk1("abort_req_valid", bus.mem_req_valid, 1'b1);
    chk32("abort_req_addr", bus.mem_req_addr, 32'h8000_0000);
    chk1("abort_req_wen", bus.mem_req_wen, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_rst_req_valid", bus.mem_req_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0000_0413;
    bus.ifu_resp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("post_rst_req_valid", bus.mem_req_valid, 1'b0);
      chk1("post_rst_resp_ready", bus.mem_resp_ready, 1'b0);
      chk1("post_rst_ifu_resp_valid", bus.ifu_resp_valid, 1'b0);
      chk32("post_rst_ifu_rdata", bus.ifu_resp_rdata, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25010008_arbiter.md
YSYX_25010008_ARBITER -- requirements
Module: ysyx_25010008_Arbiter

Interface
REQ-001 SHALL have one clock, and reset SHALL be synchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ifu_req_valid  input  1  IFU fetch request pending.
REQ-005 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-006 ifu_req_addr  input  32  IFU fetch address.
REQ-007 ifu_resp_valid  output  1  fetch data valid.
REQ-008 ifu_resp_ready  input  1  IFU accepts response.
REQ-009 ifu_resp_rdata  output  32  fetched instruction word.
REQ-010 lsu_req_valid  input  1  LSU load/store request pending.
REQ-011 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-012 lsu_req_addr  input  32  LSU byte address.
REQ-013 lsu_req_wen  input  1  1 = store, 0 = load.
REQ-014 lsu_req_wdata  input  32  store data.
REQ-015 lsu_req_wmask  input  4  store byte-lane mask.
REQ-016 lsu_resp_valid  output  1  load data / store ack valid.
REQ-017 lsu_resp_ready  input  1  LSU accepts response.
REQ-018 lsu_resp_rdata  output  32  load data (don't-care for stores).
REQ-019 mem_req_valid  output  1  request to memory.
REQ-020 mem_req_ready  input  1  memory accepts request.
REQ-021 mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wmask  output  32/1/32/4  forwarded request fields.
REQ-022 mem_resp_valid  input  1  memory response valid.
REQ-023 mem_resp_ready  output  1  arbiter accepts memory response.
REQ-024 mem_resp_rdata  input  32  memory read data.

Function
REQ-025 FSM states: IDLE, IFU_REQ, IFU_RESP, LSU_REQ, LSU_RESP; exactly one transaction outstanding at a time.
REQ-026 IDLE: ifu_req_ready/lsu_req_ready driven combinationally; only the granted master sees ready=1, and only when its valid=1.
REQ-027 Single requester in IDLE: granted. Both valid: round-robin, grant the master not granted last; last_grant updates on every grant.
REQ-028 On grant, capture addr/wen/wdata/wmask into holding registers; IFU grant forces wen=0, wmask=0, wdata=0. Next state IFU_REQ or LSU_REQ.
REQ-029 *_REQ states: mem_req_valid=1 with held fields, stable until mem_req_ready=1; on handshake go to the matching *_RESP state.
REQ-030 *_RESP states: mem_resp_ready = granted master's resp_ready; granted master's resp_valid = mem_resp_valid; resp_rdata = mem_resp_rdata (combinational pass-through).
REQ-031 Handshake of mem_resp_valid with mem_resp_ready returns FSM to IDLE; a new grant is possible in the following cycle (minimum 3 cycles per transaction with a zero-wait memory).
REQ-032 Non-granted master: resp_valid=0, req_ready=0 outside IDLE; its request stays pending, with no loss.
REQ-033 mem_resp_valid in IDLE or *_REQ states: mem_resp_ready=0, response ignored.
REQ-034 resp_rdata outputs SHALL be 0 whenever the matching resp_valid=0.

Reset
REQ-035 rst=1: state=IDLE, holding registers=0, last_grant=LSU (IFU wins the first contention); outputs mem_req_valid=0, mem_resp_ready=0, all resp_valid=0, all req_ready=0 during reset.
REQ-036 rst asserted mid-transaction aborts it; memory responses arriving after reset are ignored per REQ-033.

Verification
REQ-037 IFU alone, addr=0x80000000, memory ready immediately, rdata=0x00000413 -> ifu_req_ready cycle 0; mem_req_valid cycle 1 with addr 0x80000000 and wen=0; ifu_resp_rdata=0x00000413 when mem_resp_valid.
REQ-038 IFU and LSU valid in the same cycle after reset -> IFU granted first, LSU granted in the IDLE cycle after IFU response completes, and LSU request fields unchanged.
REQ-039 LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0x3, mem_req_ready held 0 for 4 cycles -> mem_req fields stable all 4 cycles; one handshake only.
REQ-040 LSU load in LSU_RESP with lsu_resp_ready=0 for 3 cycles -> mem_resp_ready=0 for those cycles; FSM stays in LSU_RESP; completes on first ready=1.
REQ-041 rst pulsed while in IFU_REQ, then spurious mem_resp_valid=1 -> mem_req_valid=0 next cycle, mem_resp_ready=0, no ifu_resp_valid.
